// File: rtl/step_sequencer.sv
// step_sequencer: walks a 3-bit step index for a 74138-style decoder.
// One active-low strobe per step, with ready-driven wait states, a
// wait-state timeout, abort, and one-cycle done/timeout pulses.
// Every output comes straight from a flop.
module step_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] last_step,
    input  logic       ready,
    input  logic       abort,
    output logic [2:0] A,
    output logic       N_E1,
    output logic       N_E2,
    output logic       E3,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    // Wait counter is wide enough to hold MAX_WAIT; at least one bit.
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WC_SAT = {WW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_a;
    logic [2:0]      r_lim;
    logic [WW-1:0]   r_wait_cnt;
    logic            r_ne1;
    logic            r_ne2;
    logic            r_e3;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout;

    assign A       = r_a;
    assign N_E1    = r_ne1;
    assign N_E2    = r_ne2;
    assign E3      = r_e3;
    assign busy    = r_busy;
    assign done    = r_done;
    assign timeout = r_timeout;

    // Sequencer FSM: outputs are registered from the next state, so the
    // decoder enables track RUN exactly and pulses last a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= 3'd0;
            r_lim      <= 3'd0;
            r_wait_cnt <= '0;
            r_ne1      <= 1'b1;
            r_ne2      <= 1'b1;
            r_e3       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (abort) begin
            // Kill whatever is running; A keeps its last value.
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_ne1      <= 1'b1;
            r_ne2      <= 1'b1;
            r_e3       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_lim      <= last_step;
                        r_a        <= 3'd0;
                        r_wait_cnt <= '0;
                        r_ne1      <= 1'b0;
                        r_ne2      <= 1'b0;
                        r_e3       <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (ready) begin
                        r_wait_cnt <= '0;
                        if (r_a != r_lim) begin
                            r_a <= r_a + 3'd1;
                        end else begin
                            // Last step completed; A stays at lim.
                            r_state <= S_DONE;
                            r_ne1   <= 1'b1;
                            r_ne2   <= 1'b1;
                            r_e3    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (MAX_WAIT != 0 && int'(r_wait_cnt) == MAX_WAIT - 1) begin
                        // Step stalled too long: give up without done.
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                        r_ne1      <= 1'b1;
                        r_ne2      <= 1'b1;
                        r_e3       <= 1'b0;
                        r_busy     <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else if (r_wait_cnt != WC_SAT) begin
                        // Stretch the strobe; counter saturates instead of wrapping.
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ne1   <= 1'b1;
                    r_ne2   <= 1'b1;
                    r_e3    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus a random run, all
// compared against a sequence-level reference model and a 74138 decode.
module tb_step_sequencer;

    localparam int MW   = 4;
    localparam int WW   = (MW < 1) ? 1 : $clog2(MW + 1);
    localparam int WSAT = (1 << WW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] last_step = 3'd0;
    logic       ready = 1'b1;
    logic       abort = 1'b0;
    logic [2:0] A;
    logic       N_E1, N_E2, E3, busy, done, timeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_run = 0, m_a = 0, m_lim = 0, m_wait = 0, m_done = 0, m_to = 0;

    step_sequencer #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .last_step(last_step),
        .ready(ready), .abort(abort), .A(A), .N_E1(N_E1), .N_E2(N_E2),
        .E3(E3), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sequence-level behaviour: a run walks 0..lim, each step completes on
    // ready, MW consecutive stalls on one step abandon the run.
    task automatic model_step();
        int pd, pt;
        pd = 0; pt = 0;
        if (rst) begin
            m_run = 0; m_a = 0; m_lim = 0; m_wait = 0;
        end else if (abort) begin
            m_run = 0; m_wait = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_lim = int'(last_step); m_a = 0; m_wait = 0;
            end
        end else if (ready) begin
            m_wait = 0;
            if (m_a == m_lim) begin m_run = 0; pd = 1; end
            else m_a = m_a + 1;
        end else if (MW != 0 && m_wait + 1 == MW) begin
            m_run = 0; pt = 1; m_wait = 0;
        end else if (m_wait < WSAT) begin
            m_wait = m_wait + 1;
        end
        m_done = pd;
        m_to   = pt;
    endtask

    task automatic check_outputs();
        logic [7:0] y, ey;
        y  = (E3 && !N_E1 && !N_E2) ? ~(8'd1 << A) : 8'hFF;
        ey = m_run ? ~(8'd1 << m_a) : 8'hFF;
        chk("A", 32'(A), 32'(m_a));
        chk("busy", 32'(busy), 32'(m_run));
        chk("E3", 32'(E3), 32'(m_run));
        chk("N_E1", 32'(N_E1), 32'(!m_run));
        chk("N_E2", 32'(N_E2), 32'(!m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("decode", 32'(y), 32'(ey));
        chk("strobes", 32'($countones(~y)), 32'(m_run));
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(3);
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_E3", 32'(E3), 32'd0);

        // Plain run, last_step=3
        last_step = 3'd3; start = 1'b1; ready = 1'b1; cyc();
        start = 1'b0; last_step = 3'd6; cyc(3);
        chk("run_A3", 32'(A), 32'd3);
        cyc();
        chk("run_done", 32'(done), 32'd1);
        cyc(2);

        // Wait states on step 1, last_step=2
        last_step = 3'd2; start = 1'b1; cyc();
        start = 1'b0; cyc();
        ready = 1'b0; cyc(2);
        chk("wait_A1", 32'(A), 32'd1);
        ready = 1'b1; cyc(4);

        // Timeout on step 2, last_step=5
        last_step = 3'd5; start = 1'b1; cyc();
        start = 1'b0; cyc(2);
        ready = 1'b0; cyc(3);
        chk("to_hold", 32'(A), 32'd2);
        cyc();
        chk("to_pulse", 32'(timeout), 32'd1);
        cyc(2);
        ready = 1'b1;

        // Abort at step 3 of last_step=7
        last_step = 3'd7; start = 1'b1; cyc();
        start = 1'b0; cyc(3);
        abort = 1'b1; cyc();
        chk("abort_busy", 32'(busy), 32'd0);
        abort = 1'b0; cyc(2);

        // Back-to-back: start held through DONE
        last_step = 3'd0; start = 1'b1; cyc();
        last_step = 3'd1; cyc();
        chk("b2b_done", 32'(done), 32'd1);
        cyc();
        chk("b2b_strobe", 32'(E3), 32'd1);
        start = 1'b0; cyc(3);

        // Reset mid-run at step 4
        last_step = 3'd7; start = 1'b1; cyc();
        start = 1'b0; cyc(4);
        rst = 1'b1; cyc();
        chk("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0; cyc(2);

        // Random run
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 99) < 30);
            last_step = 3'($urandom_range(0, 7));
            ready     = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 80 : 40));
            abort     = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
